// File: rtl/burst_host.sv
// Traffic source and checker: sends an LFSR-generated burst, then checks the echoed burst.
// Optional watchdog on the return path is enabled by defining BURST_HOST_TIMEOUT_EN.
module burst_host #(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_m1,
    input  logic [DATA_W-1:0] seed,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              short_burst,
    output logic              timeout,
    output logic [LEN_W:0]    err_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    // The LFSR taps are hard-wired for a 16-bit word.
    generate
        if (DATA_W != 16) begin : g_bad_data_w
            $error("burst_host: DATA_W must be 16");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("burst_host: TIMEOUT must be at least 1");
        end
    endgenerate

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    state_t            state_q;
    logic              tx_valid_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              short_q;
    logic [LEN_W:0]    err_cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] tx_lfsr_q;
    logic [DATA_W-1:0] rx_lfsr_q;
    logic [LEN_W:0]    tx_cnt_q;
    logic [LEN_W:0]    rx_cnt_q;

    logic [DATA_W-1:0] seed_d;
    logic              rx_hit_d;
    logic              rx_last_d;
    logic [LEN_W:0]    err_cnt_d;

    assign seed_d    = (seed == '0) ? DATA_W'(16'hACE1) : seed;
    assign rx_hit_d  = rx_valid && ((state_q == WAIT) || (state_q == RECV));
    assign rx_last_d = (rx_cnt_q == {1'b0, len_q});

    // Error count includes the word compared this cycle so the final verdict sees it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rx_hit_d && (rx_data != rx_lfsr_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

`ifdef BURST_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            short_q    <= 1'b0;
            err_cnt_q  <= '0;
            len_q      <= '0;
            tx_lfsr_q  <= '0;
            rx_lfsr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
`ifdef BURST_HOST_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q      <= len_m1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= seed_d;
                        tx_lfsr_q  <= lfsr_step(seed_d);
                        rx_lfsr_q  <= seed_d;
                        tx_cnt_q   <= '0;
                        rx_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        short_q    <= 1'b0;
                        err_cnt_q  <= '0;
`ifdef BURST_HOST_TIMEOUT_EN
                        wd_q       <= '0;
                        timeout_q  <= 1'b0;
`endif
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_cnt_q == {1'b0, len_q}) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        state_q    <= WAIT;
                    end else begin
                        tx_data_q <= tx_lfsr_q;
                        tx_lfsr_q <= lfsr_step(tx_lfsr_q);
                        tx_cnt_q  <= tx_cnt_q + 1'b1;
                    end
                end
                WAIT, RECV: begin
                    if (rx_valid) begin
                        rx_lfsr_q <= lfsr_step(rx_lfsr_q);
                        rx_cnt_q  <= rx_cnt_q + 1'b1;
`ifdef BURST_HOST_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                        if (rx_last_d) begin
                            pass_q  <= (err_cnt_d == '0);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            state_q <= RECV;
                        end
                    end else if (state_q == RECV) begin
                        // Once the echo has begun it must be contiguous.
                        short_q <= 1'b1;
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
`ifdef BURST_HOST_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign short_burst = short_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_burst_host.sv
// Bench for burst_host: plays the echo core, corrupting/truncating the return burst,
// and checks every transaction against an LFSR-sequence reference model.
`timescale 1ns/1ps
module tb_burst_host;

    localparam int DATA_W  = 16;
    localparam int LEN_W   = 12;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len_m1;
    logic [DATA_W-1:0] seed;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              short_burst;
    logic              timeout;
    logic [LEN_W:0]    err_cnt;

    int passed = 0;
    int total  = 0;

    logic [15:0] exp_q[$];
    logic [15:0] txcap[$];

    always #5 clk = ~clk;

    burst_host #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .seed(seed),
        .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .done(done), .pass(pass), .short_burst(short_burst),
        .timeout(timeout), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction: n_ret words are echoed back (c0/c1 get bit 0 flipped),
    // extra junk words follow a complete echo, start is pulsed at return word start_at.
    task automatic run_txn(input string name, input logic [15:0] s, input int L, input int n_ret,
                           input int gap, input int c0, input int c1, input int extra,
                           input int start_at);
        logic [15:0]    w;
        int             n_tx, tx_bad, early, tx_seen, exp_err, exp_done_at, done_at, n_done;
        logic           exp_pass, exp_short, exp_to;
        logic           pass_s, short_s, to_s, busy_s;
        logic [LEN_W:0] err_s;

        exp_q.delete();
        txcap.delete();
        w = (s == 16'h0000) ? 16'hACE1 : s;
        for (int i = 0; i <= L; i++) begin
            exp_q.push_back(w);
            w = {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
        end
        exp_err = 0;
        for (int i = 0; i < n_ret; i++) if (i == c0 || i == c1) exp_err++;
        exp_short = (n_ret > 0) && (n_ret < L + 1);
        exp_pass  = (exp_err == 0) && (n_ret == L + 1);
        exp_to    = 1'b0;
        if (n_ret == L + 1) exp_done_at = 0;
        else if (n_ret > 0) exp_done_at = 1;
        else begin
`ifdef BURST_HOST_TIMEOUT_EN
            exp_done_at = TIMEOUT - gap;
            exp_to      = 1'b1;
`else
            exp_done_at = -1;
`endif
        end

        @(negedge clk);
        start  = 1'b1;
        len_m1 = LEN_W'(L);
        seed   = s;
        @(negedge clk);
        start  = 1'b0;
        len_m1 = LEN_W'($urandom);
        seed   = 16'($urandom);
        chk({name, ".tx_rise"}, {tx_valid, busy}, 2'b11);
        chk({name, ".first_word"}, tx_data, exp_q[0]);

        n_tx = 0; tx_bad = 0; early = 0;
        while (tx_valid && n_tx < 5000) begin
            if (n_tx > L) tx_bad++;
            else if (tx_data !== exp_q[n_tx]) tx_bad++;
            if (!busy || done) early++;
            txcap.push_back(tx_data);
            n_tx++;
            rx_valid = 1'($urandom);
            rx_data  = 16'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = '0;
        chk({name, ".tx_len"}, n_tx, L + 1);
        chk({name, ".tx_seq"}, tx_bad, 0);
        chk({name, ".tx_idle_data"}, tx_data, 16'h0000);
        chk({name, ".wait_busy"}, busy, 1'b1);

        tx_seen = 0;
        repeat (gap) begin
            if (done) early++;
            if (tx_valid) tx_seen++;
            @(negedge clk);
        end
        for (int i = 0; i < n_ret; i++) begin
            if (done) early++;
            if (tx_valid) tx_seen++;
            rx_valid = 1'b1;
            rx_data  = exp_q[i] ^ ((i == c0 || i == c1) ? 16'h0001 : 16'h0000);
            start    = (i == start_at);
            @(negedge clk);
        end
        start = 1'b0;

        done_at = -1; n_done = 0;
        pass_s = 1'b0; short_s = 1'b0; to_s = 1'b0; busy_s = 1'b1; err_s = '0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = c; pass_s = pass; short_s = short_burst;
                    to_s = timeout; busy_s = busy; err_s = err_cnt;
                end
            end
            if (tx_valid) tx_seen++;
            rx_valid = (c < extra);
            rx_data  = 16'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;

        chk({name, ".early_done"}, early, 0);
        chk({name, ".no_restart"}, tx_seen, 0);
        chk({name, ".done_at"}, done_at, exp_done_at);
        chk({name, ".done_pulses"}, n_done, (exp_done_at >= 0) ? 1 : 0);
        if (exp_done_at >= 0) begin
            chk({name, ".pass"}, pass_s, exp_pass);
            chk({name, ".err_cnt"}, err_s, exp_err);
            chk({name, ".short"}, short_s, exp_short);
            chk({name, ".timeout"}, to_s, exp_to);
            chk({name, ".busy_fall"}, busy_s, 1'b0);
            chk({name, ".pass_held"}, pass, exp_pass);
            chk({name, ".err_held"}, err_cnt, exp_err);
        end else begin
            chk({name, ".still_busy"}, busy, 1'b1);
        end
        $display("txn %s seed=%h len_m1=%0d returned=%0d done_at=%0d err_cnt=%0d pass=%0b short=%0b timeout=%0b",
                 name, s, L, n_ret, done_at, err_s, pass_s, short_s, to_s);
    endtask

    initial begin
        int L, n_ret, c0, c1, gap, extra, cnt, bad;
        bit full;

        rst_n = 1'b0; start = 1'b0; len_m1 = '0; seed = '0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset.ctrl", {tx_valid, busy, done, pass, short_burst, timeout}, 6'b0);
        chk("reset.data", {err_cnt, tx_data}, 29'h0);
        rst_n = 1'b1;

        run_txn("echo4", 16'h0001, 3, 4, 2, -1, -1, 0, -1);
        chk("echo4.w1", txcap[1], 16'h0002);
        chk("echo4.w2", txcap[2], 16'h0004);
        chk("echo4.w3", txcap[3], 16'h0008);

        run_txn("corrupt", 16'($urandom), 7, 8, 1, 2, 5, 0, -1);
        run_txn("short", 16'($urandom), 9, 6, 0, -1, -1, 0, -1);
        run_txn("zero_full", 16'h0000, 4095, 4096, 3, -1, -1, 0, -1);
        chk("zero_full.ace1", txcap[0], 16'hACE1);
        run_txn("len1", 16'($urandom), 0, 1, 0, -1, -1, 2, -1);
        run_txn("extra_words", 16'($urandom), 5, 6, 0, 4, -1, 3, -1);
        run_txn("start_in_recv", 16'($urandom), 9, 10, 0, -1, -1, 0, 4);

        for (int t = 0; t < 8; t++) begin
            L     = $urandom_range(0, 40);
            full  = ($urandom_range(0, 2) != 0) || (L == 0);
            n_ret = full ? L + 1 : $urandom_range(1, L);
            c0    = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, L);
            c1    = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, L);
            gap   = $urandom_range(0, 8);
            extra = full ? $urandom_range(0, 3) : 0;
            run_txn($sformatf("rnd%0d", t), 16'($urandom), L, n_ret, gap, c0, c1, extra, -1);
        end

        // No response at all: watchdog fires, or (no watchdog) the host waits forever.
        run_txn("no_response", 16'($urandom), 4, 0, 0, -1, -1, 0, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_wait.busy", busy, 1'b0);

        // Reset in SEND aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; len_m1 = LEN_W'(20); seed = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_send.pre", tx_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_send.ctrl", {tx_valid, busy, done, pass, short_burst, timeout}, 6'b0);
        chk("rst_send.data", {err_cnt, tx_data}, 29'h0);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            if (done || tx_valid || busy) bad++;
            @(negedge clk);
        end
        chk("rst_send.quiet", bad, 0);

        // Back-to-back: start held high is taken in the first IDLE cycle after DONE.
        start = 1'b1; len_m1 = LEN_W'(1); seed = 16'h00F0;
        @(negedge clk);
        cnt = 0;
        while (tx_valid && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        chk("b2b.tx_len", cnt, 2);
        rx_valid = 1'b1; rx_data = 16'h00F0;
        @(negedge clk);
        rx_data = 16'h01E0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("b2b.done_pass", {done, pass}, 2'b11);
        cnt = 0;
        while (!tx_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b.restart", cnt, 2);
        $display("txn b2b seed=00f0 len_m1=1 restart_after=%0d", cnt);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/burst_host.md
# burst_host

Host-side counterpart of the burst store-and-echo core. It generates a pseudo-random burst of 16-bit words and drives it on the core's valid/data input, then receives the echoed burst from the core's output. Each returned word is compared against a regenerated copy of the sent sequence, and the block reports pass/fail plus an error count. It sits at the top of the design as the traffic source and checker.

## Interface
- `DATA_W`, 16, word width; the LFSR is fixed at 16 bits, so this must be 16.
- `LEN_W`, 12, burst length field width; allows up to 4096 words, matching the core memory depth.
- `TIMEOUT`, 1024, watchdog limit in cycles, used only when `BURST_HOST_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `len_m1`  in  LEN_W  burst length minus one; sampled with `start`.
- `seed`  in  16  first word of the burst; sampled with `start`. A value of 0 is replaced by 16'hACE1.
- `tx_valid`  out  1  drives the core's in_valid.
- `tx_data`  out  16  drives the core's in_data.
- `rx_valid`  in  1  from the core's out_valid.
- `rx_data`  in  16  from the core's out_data.
- `busy`  out  1  high in SEND, WAIT and RECV.
- `done`  out  1  one-cycle pulse when the transaction ends.
- `pass`  out  1  result; valid from `done` until the next accepted `start`.
- `short_burst`  out  1  `rx_valid` dropped before all words were received.
- `timeout`  out  1  watchdog fired.
- `err_cnt`  out  LEN_W+1  count of mismatched words; saturates at all-ones.

## Operation
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE
  - When `start`=1: latch `len_m1` and `seed` (applying the zero substitution).
  - Clear `err_cnt`, `pass`, `short_burst` and `timeout`.
  - Load the TX LFSR and the RX LFSR with the latched seed.
  - Go to SEND.
- SEND
  - `tx_valid`=1 and `tx_data` = current TX LFSR state.
  - The TX LFSR advances every cycle.
  - The word counter runs from 0 to `len_m1`; after the last word, go to WAIT.
  - `rx_valid` is ignored in this state.
- LFSR step: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}. Word k is the seed stepped k times.
- WAIT
  - The first cycle with `rx_valid`=1 compares that cycle's word 0 and goes to RECV.
- RECV
  - Each `rx_valid` cycle: compare `rx_data` with the RX LFSR, increment `err_cnt` on mismatch (saturating), then advance the RX LFSR.
  - After `len_m1`+1 words have been compared, go to DONE.
  - `rx_valid`=0 before the last word: set `short_burst`=1 and go to DONE.
- DONE
  - `done` pulses for exactly one cycle.
  - `pass` = (`err_cnt`==0) && !`short_burst` && !`timeout`.
  - Go to IDLE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Extra `rx_valid` words arriving after DONE are ignored.
- Counters are LEN_W+1 bits, so `len_m1` = all-ones (4096 words) does not wrap early.

## Timing
- All outputs are registered.
- Reset values:
  - `tx_valid`, `tx_data`, `busy`, `done`, `pass`, `short_burst`, `timeout` and `err_cnt` are all 0.
  - State is IDLE.
- Reset mid-transaction aborts immediately: `tx_valid` is 0 on the next cycle, with no `done` pulse.
- `start` is sampled in cycle T:
  - `tx_valid` and `busy` rise at T+1.
  - `tx_valid` stays high for exactly `len_m1`+1 contiguous cycles.
  - `tx_data` is 0 whenever `tx_valid`=0.
- Comparison is performed in the same cycle `rx_valid` is seen.
- `done` is asserted the cycle after the last word or the error condition is detected. `busy` falls in that same cycle.
- Back-to-back: a `start` held high is accepted in the first IDLE cycle after DONE.

## Configuration
- `BURST_HOST_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and RECV and is cleared on every `rx_valid`=1.
  - When it reaches `TIMEOUT`: set `timeout`=1 and go to DONE (`pass`=0).
- Not defined:
  - No watchdog; WAIT lasts indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Echo, 4 words: `seed`=16'h0001, `len_m1`=3, with the core looping back. Required:
  - `tx_data` = 0001, 0002, 0004, 0008.
  - `done` pulse with `pass`=1 and `err_cnt`=0.
- Corruption: `len_m1`=7, bench flips bit 0 of rx words 2 and 5. Required: `err_cnt`=2 and `pass`=0.
- Short return: `len_m1`=9, only 6 rx words returned. Required: `short_burst`=1, `pass`=0, `done` the cycle after `rx_valid` falls.
- Zero seed with full length: `seed`=0, `len_m1`=12'hFFF. Required:
  - First `tx_data` = ACE1.
  - Exactly 4096 `tx_valid` cycles.
  - `pass`=1 on a clean echo.
- Timeout (macro on, `TIMEOUT`=16): no rx response. Required: `timeout`=1 and `done` 16 cycles after entering WAIT. With the macro off, `busy` stays 1.
- Reset and start handling: `rst_n`=0 during SEND, then a `start` pulse in RECV. Required:
  - Outputs return to 0 on the next cycle with no `done` pulse.
  - The `start` pulse in RECV is ignored.
